// File: rtl/top.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key schedule.
// Ports: clk, reset (async low), start (edge-detected), data/key in, encReady/outData out.
module aesSbox (
    input  logic [7:0] x,
    output logic [7:0] s
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign s = SBOX[x];
endmodule

module top (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] data,
    input  logic [127:0] key,
    output logic         encReady,
    output logic [127:0] outData
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsmState_t;

    fsmState_t    fsmState;
    fsmState_t    fsmNext;
    logic         startD;
    logic [3:0]   round;
    logic [127:0] stateReg;
    logic [127:0] roundKey;

    logic         accept;
    logic         lastRound;
    logic [7:0]   rcon;
    logic [31:0]  rotWord;
    logic [31:0]  subWord;
    logic [31:0]  temp;
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [127:0] nextKey;
    logic [127:0] subState;
    logic [127:0] shiftState;
    logic [127:0] mixState;
    logic [127:0] roundOut;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Edge detect: a level held high only fires once.
    assign accept    = start && !startD && (fsmState != BUSY);
    assign lastRound = (round == 4'd10);

    // Counter value equals the round being computed this cycle.
    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Key schedule: RotWord on last word, then SubWord and Rcon.
    assign rotWord = {roundKey[23:0], roundKey[31:24]};

    for (genvar i = 0; i < 4; i++) begin : gKeySbox
        aesSbox uSbox (
            .x (rotWord[8*i +: 8]),
            .s (subWord[8*i +: 8])
        );
    end

    assign temp    = subWord ^ {rcon, 24'h000000};
    assign kw0     = roundKey[127:96] ^ temp;
    assign kw1     = roundKey[95:64] ^ kw0;
    assign kw2     = roundKey[63:32] ^ kw1;
    assign kw3     = roundKey[31:0] ^ kw2;
    assign nextKey = {kw0, kw1, kw2, kw3};

    // Byte b sits at row b%4, column b/4.
    for (genvar b = 0; b < 16; b++) begin : gStateSbox
        aesSbox uSbox (
            .x (stateReg[127-8*b -: 8]),
            .s (subState[127-8*b -: 8])
        );
    end

    // Row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : gShiftCol
        for (genvar r = 0; r < 4; r++) begin : gShiftRow
            localparam int SRC = 4 * ((c + r) % 4) + r;
            assign shiftState[127-8*(4*c+r) -: 8] =
                subState[127-8*SRC -: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : gMixCol
        logic [7:0] a0, a1, a2, a3;
        assign a0 = shiftState[127-32*c -: 8];
        assign a1 = shiftState[119-32*c -: 8];
        assign a2 = shiftState[111-32*c -: 8];
        assign a3 = shiftState[103-32*c -: 8];
        assign mixState[127-32*c -: 8] =
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mixState[119-32*c -: 8] =
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mixState[111-32*c -: 8] =
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mixState[103-32*c -: 8] =
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    // Final round skips MixColumns.
    assign roundOut = (lastRound ? shiftState : mixState) ^ nextKey;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsmState <= IDLE;
        else        fsmState <= fsmNext;
    end

    always_comb begin
        fsmNext = fsmState;
        unique case (fsmState)
            IDLE, DONE: if (accept) fsmNext = BUSY;
            BUSY:       if (lastRound) fsmNext = DONE;
            default:    fsmNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            startD   <= 1'b0;
            round    <= 4'd0;
            stateReg <= '0;
            roundKey <= '0;
            outData  <= '0;
            encReady <= 1'b0;
        end else begin
            startD <= start;
            if (accept) begin
                stateReg <= data ^ key;
                roundKey <= key;
                round    <= 4'd1;
                encReady <= 1'b0;
            end else if (fsmState == BUSY) begin
                stateReg <= roundOut;
                roundKey <= nextKey;
                if (lastRound) begin
                    outData  <= roundOut;
                    encReady <= 1'b1;
                end else begin
                    round <= round + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_top.sv
// Self-checking bench for the AES-128 encryptor: known answers plus
// random blocks against a byte-level reference model.
module tb_top;
    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] data;
    logic [127:0] key;
    logic         encReady;
    logic [127:0] outData;

    int total = 0;
    int bad   = 0;

    logic [7:0] sboxT [256];

    top dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data     (data),
        .key      (key),
        .encReady (encReady),
        .outData  (outData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h00;
        for (int i = 1; i < 256; i++)
            if (a != 8'h00 && gmul(a, 8'(i)) == 8'h01) r = 8'(i);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aesRef(input logic [127:0] k, input logic [127:0] d);
        logic [7:0] rk [176];
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [7:0] t [4];
        logic [7:0] rc = 8'h01;
        logic [7:0] x;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) rk[i] = k[127-8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                x = t[0];
                t[0] = sboxT[t[1]] ^ rc;
                t[1] = sboxT[t[2]];
                t[2] = sboxT[t[3]];
                t[3] = sboxT[x];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ t[j];
        end
        for (int i = 0; i < 16; i++) st[i] = d[127-8*i -: 8] ^ rk[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) st[i] = sboxT[st[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[4*c+r] = st[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    st[4*c]   = gmul(tmp[4*c], 8'd2) ^ gmul(tmp[4*c+1], 8'd3)
                              ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ gmul(tmp[4*c+1], 8'd2)
                              ^ gmul(tmp[4*c+2], 8'd3) ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1]
                              ^ gmul(tmp[4*c+2], 8'd2) ^ gmul(tmp[4*c+3], 8'd3);
                    st[4*c+3] = gmul(tmp[4*c], 8'd3) ^ tmp[4*c+1]
                              ^ tmp[4*c+2] ^ gmul(tmp[4*c+3], 8'd2);
                end else begin
                    for (int r = 0; r < 4; r++) st[4*c+r] = tmp[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic waitReady(output int lat);
        lat = 0;
        while (encReady !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic doOp(input string tag, input logic [127:0] k,
                        input logic [127:0] d, input logic [127:0] prevOut,
                        input logic [127:0] expOut);
        int lat;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        key = k; data = d; start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_rdyLow"}, 128'(encReady), 128'd0);
        chk({tag, "_outHeld"}, outData, prevOut);
        waitReady(lat);
        chk({tag, "_lat"}, 128'(lat), 128'd10);
        chk({tag, "_out"}, outData, expOut);
    endtask

    initial begin
        int lat;
        logic [127:0] k0, d0, expv, prev;

        for (int i = 0; i < 256; i++) sboxT[i] = affine(ginv(8'(i)));

        reset = 1'b0; start = 1'b0; data = '0; key = '0;
        #1;
        chk("rstOut", outData, 128'd0);
        chk("rstRdy", 128'(encReady), 128'd0);
        chk("refC1", aesRef(128'h000102030405060708090a0b0c0d0e0f,
                            128'h00112233445566778899aabbccddeeff),
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Zero block, start already high when reset releases.
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        data = '0;
        start = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("zeroRdyLow", 128'(encReady), 128'd0);
        waitReady(lat);
        chk("zeroLat", 128'(lat), 128'd10);
        chk("zeroOut", outData, 128'h7df76b0c1ab899b33e42f047b91b546f);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("zeroHoldRdy", 128'(encReady), 128'd1);
            chk("zeroHoldOut", outData, 128'h7df76b0c1ab899b33e42f047b91b546f);
        end

        doOp("appB", 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3243f6a8885a308d313198a2e0370734,
             128'h7df76b0c1ab899b33e42f047b91b546f,
             128'h3925841d02dc09fbdc118597196a0b32);
        doOp("c1", 128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff,
             128'h3925841d02dc09fbdc118597196a0b32,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        prev = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        // Inputs change and start re-pulses while busy.
        k0 = rand128(); d0 = rand128();
        expv = aesRef(k0, d0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); key = k0; data = d0; start = 1'b1;
        @(posedge clk); #1;
        chk("midRdyLow", 128'(encReady), 128'd0);
        lat = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; lat++;
        end
        @(negedge clk); key = rand128(); data = rand128(); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1; lat += 3;
        while (encReady !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("midLat", 128'(lat), 128'd10);
        chk("midOut", outData, expv);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("midNoQueue", 128'(encReady), 128'd1);
        end
        chk("midHoldOut", outData, expv);

        // Reset mid-operation.
        k0 = rand128(); d0 = rand128();
        @(negedge clk); key = k0; data = d0; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abortOut", outData, 128'd0);
        chk("abortRdy", 128'(encReady), 128'd0);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) @(posedge clk);
        #1;
        chk("abortNoResOut", outData, 128'd0);
        chk("abortNoResRdy", 128'(encReady), 128'd0);
        doOp("afterAbort", k0, d0, 128'd0, aesRef(k0, d0));
        prev = aesRef(k0, d0);

        for (int n = 0; n < 8; n++) begin
            k0 = rand128(); d0 = rand128();
            if (n == 0) k0 = '1;
            if (n == 1) d0 = '1;
            expv = aesRef(k0, d0);
            doOp("rand", k0, d0, prev, expv);
            prev = expv;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
